sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
- Time-multiplexed N-digit seven-segment scan driver for the Nexys A7 8-digit display.
- Takes packed hex nibbles, per-digit decimal points and an enable mask, and scans one digit at a time at a programmable rate.
- Adds tear-free double buffering, leading-zero suppression and an anti-ghosting guard interval.
- Sits between the counter/datapath logic and the board AN/CA..CG/DP pins.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (1..8).
- TICK_DIV, 12500, clk cycles per digit slot (100 MHz / 12500 = 8 kHz slot rate, 1 kHz frame at 8 digits); must be >= 2.
- GUARD, 16, cycles at slot start with all anodes off; must be < TICK_DIV.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- hex_in  in  4*NUM_DIGITS  nibble i at [4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit
- digit_en  in  NUM_DIGITS  per-digit enable, 0 = blank
- load  in  1  single-cycle strobe; captures hex_in/dp_in/digit_en into the pending buffer
- lz_en  in  1  leading-zero suppression enable, sampled with active buffer
- AN  out  NUM_DIGITS  anode enables, active-low
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low
- scan_idx  out  $clog2(NUM_DIGITS) (min 1)  digit currently in its slot
- frame_start  out  1  one-cycle pulse when scan_idx wraps to 0

Behaviour:
- Reset (async assert, sync release): div_cnt=0, scan_idx=0, pending and active buffers all 0 (digit_en=0), AN=all 1, sseg=7'h7F, DP=1, frame_start=0.
- Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps.
  - When div_cnt==TICK_DIV-1: scan_idx advances; from NUM_DIGITS-1 it wraps to 0.
  - The wrap to 0 registers frame_start=1 for exactly one cycle, aligned with scan_idx becoming 0.
- Buffers:
  - load=1 overwrites the pending buffer on that edge.
  - Pending is copied into active on the same edge that scan_idx wraps to 0. No mid-frame change is ever visible.
  - If load coincides with that copy edge, active receives the old pending contents; the new data lands in pending and is shown from the following frame.
  - lz_en is latched into active together with the buffer.
- Leading-zero suppression (when latched lz_en=1): digit i is blanked if its nibble==0 and every enabled digit j>i also has nibble 0 or is disabled.
  - Digit 0 is never suppressed.
  - Suppressed digits also blank their DP.
- Decode: hex 0-F to active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Outputs are registered, with 1 cycle latency from the div_cnt/scan_idx state to AN/sseg/DP.
  - Guard phase (div_cnt < GUARD): AN=all 1, sseg=7'h7F, DP=1.
  - Active phase, digit enabled and not suppressed: AN has bit scan_idx=0 and all other bits 1; sseg=decode; DP=~dp.
  - Active phase, digit blanked: AN=all 1, sseg=7'h7F, DP=1.
- At most one AN bit is low in any cycle.
- A reset asserted mid-scan immediately forces the reset values. Scanning restarts at digit 0 with a full slot.

Test Plan (NUM_DIGITS=4, TICK_DIV=8, GUARD=2):
- Reset release, no load -> AN=4'b1111, sseg=7'h7F, DP=1 for 3 frames; frame_start pulses every 32 cycles.
- load hex_in=16'h1A3F, digit_en=4'hF, dp_in=4'b0010 -> from the next frame: digit0 F (0001110), digit1 3 (0110000) with DP=0, digit2 A, digit3 1. Each digit shows AN low for 6 of 8 cycles and is off for the 2 guard cycles.
- lz_en=1, hex_in=16'h0070, digit_en=4'hF -> digits 3 and 2 blank (AN stays 1111 in their slots); digit1 shows 7; digit0 shows 0 (1000000).
- load pulsed mid-frame at scan_idx=2 with new data -> remaining slots of the current frame still show old data; new data appears exactly at the frame_start edge.
- load asserted on the same edge as the scan_idx 3->0 wrap -> the old pending data is displayed for that frame; the new data appears one frame later.
- reset pulsed while scan_idx=2, div_cnt=5 -> outputs go to reset values in the same cycle. After release, scan_idx=0, the first frame_start comes 32 cycles later, and all digits are blank until the next load.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered digits,
// leading-zero suppression and an all-off guard interval at each slot start.
// Outputs are registered one cycle after the div_cnt/scan_idx state; no backpressure.
module sseg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 12500,
  parameter int GUARD      = 16,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W     = $clog2(TICK_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              sseg,
  output logic                    DP,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_start
);

  logic [CNT_W-1:0]        div_cnt;
  logic                    slot_end;
  logic                    frame_wrap;

  // Pending buffer is written by load; active buffer is what gets scanned.
  logic [4*NUM_DIGITS-1:0] pend_hex, act_hex;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_en, act_en;
  logic                    act_lz;

  logic [NUM_DIGITS-1:0]   nib_zero;
  logic [NUM_DIGITS-1:0]   quiet_above;
  logic [NUM_DIGITS-1:0]   suppress;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_lit;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              seg_dec;
  logic                    in_guard;

  assign slot_end   = (div_cnt == CNT_W'(TICK_DIV - 1));
  assign frame_wrap = slot_end && (scan_idx == IDX_W'(NUM_DIGITS - 1));
  assign in_guard   = (div_cnt < CNT_W'(GUARD));

  // Prescaler and digit scan position; frame_start marks the wrap to digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      scan_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= slot_end ? '0 : div_cnt + 1'b1;
      frame_start <= frame_wrap;
      if (slot_end) begin
        scan_idx <= frame_wrap ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // Double buffer: active only changes on the frame wrap edge, and takes the
  // pending contents as they stood before any load on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hex <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      act_hex  <= '0;
      act_dp   <= '0;
      act_en   <= '0;
      act_lz   <= 1'b0;
    end else begin
      if (load) begin
        pend_hex <= hex_in;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
      end
      if (frame_wrap) begin
        act_hex <= pend_hex;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
        act_lz  <= lz_en;
      end
    end
  end

  // Leading-zero suppression: a digit blanks when it and every digit above it
  // is zero or disabled; digit 0 always shows.
  always_comb begin
    logic run;
    nib_zero    = '0;
    quiet_above = '0;
    suppress    = '0;
    run         = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_zero[i] = (act_hex[4*i +: 4] == 4'h0);
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      quiet_above[i] = run;
      run = run & (nib_zero[i] | ~act_en[i]);
    end
    for (int i = 1; i < NUM_DIGITS; i++) begin
      suppress[i] = act_lz & nib_zero[i] & quiet_above[i];
    end
  end

  // Select the nibble, decimal point and anode of the digit in its slot.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lit = 1'b0;
    an_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        cur_nib   = act_hex[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_lit   = act_en[i] & ~suppress[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    seg_dec = 7'h7F;
    case (cur_nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      default: seg_dec = 7'b0001110;
    endcase
  end

  // Registered pin drive; guard cycles and blanked digits keep every anode off,
  // so at most one anode is ever low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AN   <= '1;
      sseg <= 7'h7F;
      DP   <= 1'b1;
    end else if (in_guard || !cur_lit) begin
      AN   <= '1;
      sseg <= 7'h7F;
      DP   <= 1'b1;
    end else begin
      AN   <= an_sel;
      sseg <= seg_dec;
      DP   <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with 4 digits, 8-cycle slots, 2 guard cycles.
// Every cycle checks AN/sseg/DP/frame_start/scan_idx against a per-frame table.
// Loads are injected at chosen offsets inside a frame, including the wrap edge.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic        lz_en;
  logic [3:0]  AN;
  logic [6:0]  sseg;
  logic        DP;
  logic [1:0]  scan_idx;
  logic        frame_start;

  int n_vec = 0;
  int n_err = 0;
  int k     = 0;   // posedges since reset release

  // Expected per-digit appearance for the frame being displayed.
  logic       t_on  [4];
  logic [6:0] t_seg [4];
  logic       t_dp  [4];

  sseg_scan_driver #(
    .NUM_DIGITS(4),
    .TICK_DIV  (8),
    .GUARD     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .lz_en      (lz_en),
    .AN         (AN),
    .sseg       (sseg),
    .DP         (DP),
    .scan_idx   (scan_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic set_d(input int d, input logic on, input logic [6:0] sg, input logic dpo);
    t_on[d]  = on;
    t_seg[d] = sg;
    t_dp[d]  = dpo;
  endtask

  task automatic blank_all();
    for (int d = 0; d < 4; d++) set_d(d, 1'b0, 7'h7F, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},   {28'b0, AN},          32'hF);
    chk({tag, "_seg"},  {25'b0, sseg},        32'h7F);
    chk({tag, "_dp"},   {31'b0, DP},          32'h1);
    chk({tag, "_fs"},   {31'b0, frame_start}, 32'h0);
    chk({tag, "_idx"},  {30'b0, scan_idx},    32'h0);
  endtask

  // Runs n cycles checking outputs; optionally pulses load at iteration ld_at.
  task automatic frame_chk(input int n, input int ld_at, input logic [15:0] h,
                           input logic [3:0] dp, input logic [3:0] en, input logic lz);
    int         s, d, c;
    logic       lit;
    logic [3:0] e_an;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      load = 1'b0;
      s    = k - 1;
      d    = (s / 8) % 4;
      c    = s % 8;
      lit  = t_on[d] && (c >= 2);
      e_an = lit ? ~(4'b0001 << d) : 4'hF;
      chk("an",   {28'b0, AN},          {28'b0, e_an});
      chk("seg",  {25'b0, sseg},        lit ? {25'b0, t_seg[d]} : 32'h7F);
      chk("dp",   {31'b0, DP},          lit ? {31'b0, t_dp[d]} : 32'h1);
      chk("fs",   {31'b0, frame_start}, {31'b0, ((k % 32) == 0) && (k != 0)});
      chk("idx",  {30'b0, scan_idx},    (k / 8) % 4);
      if (i == ld_at) begin
        load     = 1'b1;
        hex_in   = h;
        dp_in    = dp;
        digit_en = en;
        lz_en    = lz;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    hex_in   = 16'h0;
    dp_in    = 4'h0;
    digit_en = 4'h0;
    load     = 1'b0;
    lz_en    = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    k     = 0;

    // Three blank frames; data loaded during the third shows from the fourth.
    blank_all();
    frame_chk(32, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    frame_chk(32, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    frame_chk(32, 5, 16'h1A3F, 4'b0010, 4'hF, 1'b0);

    // 1A3F with DP on digit 1; queue 0070 with suppression.
    set_d(0, 1'b1, 7'h0E, 1'b1);
    set_d(1, 1'b1, 7'h30, 1'b0);
    set_d(2, 1'b1, 7'h08, 1'b1);
    set_d(3, 1'b1, 7'h79, 1'b1);
    frame_chk(32, 3, 16'h0070, 4'b1101, 4'hF, 1'b1);

    // 0070 suppressed: digits 3,2 blank (DP too); load mid-frame at scan_idx 2.
    set_d(0, 1'b1, 7'h40, 1'b0);
    set_d(1, 1'b1, 7'h78, 1'b1);
    set_d(2, 1'b0, 7'h7F, 1'b1);
    set_d(3, 1'b0, 7'h7F, 1'b1);
    frame_chk(32, 17, 16'h5060, 4'b0000, 4'b1011, 1'b1);

    // 5060 with digit 2 disabled.
    set_d(0, 1'b1, 7'h40, 1'b1);
    set_d(1, 1'b1, 7'h02, 1'b1);
    set_d(2, 1'b0, 7'h7F, 1'b1);
    set_d(3, 1'b1, 7'h12, 1'b1);
    frame_chk(32, 3, 16'h5000, 4'b1111, 4'b0111, 1'b1);

    // 5000 with top digit disabled: zeros under it suppressed; load on wrap edge.
    set_d(0, 1'b1, 7'h40, 1'b0);
    set_d(1, 1'b0, 7'h7F, 1'b1);
    set_d(2, 1'b0, 7'h7F, 1'b1);
    set_d(3, 1'b0, 7'h7F, 1'b1);
    frame_chk(32, 30, 16'h4D21, 4'b0001, 4'hF, 1'b0);

    // Old pending (5000) shown again, now without suppression.
    set_d(0, 1'b1, 7'h40, 1'b0);
    set_d(1, 1'b1, 7'h40, 1'b0);
    set_d(2, 1'b1, 7'h40, 1'b0);
    set_d(3, 1'b0, 7'h7F, 1'b1);
    frame_chk(32, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // 4D21 one frame later; stop at scan_idx 2, div_cnt 5.
    set_d(0, 1'b1, 7'h79, 1'b0);
    set_d(1, 1'b1, 7'h24, 1'b1);
    set_d(2, 1'b1, 7'h21, 1'b1);
    set_d(3, 1'b1, 7'h19, 1'b1);
    frame_chk(21, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // Mid-scan reset takes effect without waiting for a clock edge.
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    k     = 0;

    // Buffers cleared: blank from digit 0 with a full slot, first pulse at 32.
    blank_all();
    frame_chk(32, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    frame_chk(32, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
